// File: rtl/fpu_pkg.sv
// Shared FP32 field layout and default sizing for the FPU issue-queue blocks.
package fpu_pkg;

    // FP32 field positions
    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_MAN_MSB  = 22;
    localparam int FP_MAN_LSB  = 0;
    localparam int FP_EXP_W    = FP_EXP_MSB - FP_EXP_LSB + 1;
    localparam int FP_MAN_W    = FP_MAN_MSB - FP_MAN_LSB + 1;
    localparam int FP_EXP_BIAS = 127;

    // Default queue sizing
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_TAG_W = 4;

endpackage

// File: rtl/fmul.sv
// Combinational FP32 multiplier: sign XOR, truncated mantissa, zero-exponent
// operands flush the result to zero, exponent underflow gives zero, no rounding
// and no overflow saturation (the biased exponent simply keeps its low 8 bits).
module fmul
    import fpu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);

    logic                w_sign;
    logic [FP_EXP_W-1:0] w_ea;
    logic [FP_EXP_W-1:0] w_eb;
    logic [FP_MAN_W:0]   w_ma;
    logic [FP_MAN_W:0]   w_mb;
    logic [47:0]         w_prod;
    logic                w_norm;
    logic [FP_MAN_W-1:0] w_man;
    logic [9:0]          w_exp_sum;
    logic                w_zero_in;
    logic                w_underflow;
    logic                w_unused;

    assign w_sign = i_a[FP_SIGN_BIT] ^ i_b[FP_SIGN_BIT];
    assign w_ea   = i_a[FP_EXP_MSB:FP_EXP_LSB];
    assign w_eb   = i_b[FP_EXP_MSB:FP_EXP_LSB];
    assign w_ma   = {1'b1, i_a[FP_MAN_MSB:FP_MAN_LSB]};
    assign w_mb   = {1'b1, i_b[FP_MAN_MSB:FP_MAN_LSB]};

    // 1.x * 1.y lies in [1,4): bit 47 set means the product needs one right shift.
    assign w_prod = w_ma * w_mb;
    assign w_norm = w_prod[47];
    assign w_man  = w_norm ? w_prod[46:24] : w_prod[45:23];

    // 10-bit signed exponent: range is -125..384, so bit 9 is a clean sign bit.
    assign w_exp_sum   = {2'b00, w_ea} + {2'b00, w_eb} + {9'd0, w_norm} - 10'(FP_EXP_BIAS);
    assign w_zero_in   = (w_ea == '0) || (w_eb == '0);
    assign w_underflow = w_exp_sum[9] || (w_exp_sum == 10'd0);

    // Bits below the kept mantissa are discarded by design (truncation).
    assign w_unused = ^w_prod[22:0];

    // Select flushed zero or the assembled product
    always_comb begin
        // NOTE: default first so every path assigns o_y and no latch is inferred.
        o_y = {w_sign, 31'd0};
        if (!w_zero_in && !w_underflow) begin
            o_y = {w_sign, w_exp_sum[FP_EXP_W-1:0], w_man};
        end
    end

endmodule

// File: rtl/fmul_issue_q.sv
// FP32 multiply issue queue: DEPTH-entry operand FIFO feeding one combinational
// fmul, whose result (with the request tag) is captured in a single output
// register with valid/ready handshake. Capacity is DEPTH+1 operations.
module fmul_issue_q
    import fpu_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int TAG_W = DEFAULT_TAG_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_x1,
    input  logic [31:0]              in_x2,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_y,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      r_x1_mem  [DEPTH];
    logic [31:0]      r_x2_mem  [DEPTH];
    logic [TAG_W-1:0] r_tag_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    logic [31:0]      r_out_y;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_head_y;

    // Ready depends only on occupancy, so a pop never frees a slot for the same edge.
    assign in_ready = (r_count < CNT_W'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && (!r_out_valid || out_ready);

    fmul u_fmul (
        .i_a (r_x1_mem[r_rd_ptr]),
        .i_b (r_x2_mem[r_rd_ptr]),
        .o_y (w_head_y)
    );

    // Operand storage write on accept
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; entries are only read when r_count says they are valid.
        if (w_push) begin
            r_x1_mem[r_wr_ptr]  <= in_x1;
            r_x2_mem[r_wr_ptr]  <= in_x2;
            r_tag_mem[r_wr_ptr] <= in_tag;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all state updates see pre-edge values.
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register: reload from head on pop, drop valid when drained, else hold
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_tag   <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_y     <= w_head_y;
            r_out_tag   <= r_tag_mem[r_rd_ptr];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_tag   = r_out_tag;
    assign count     = r_count;

endmodule

// File: tb/tb_fmul_issue_q.sv
// Directed bench for fmul_issue_q: single-request vector table plus
// back-to-back, backpressure/capacity and mid-operation reset sequences.
module tb_fmul_issue_q;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x1;
    logic [31:0] in_x2;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_tag;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    fmul_issue_q #(.DEPTH(4), .TAG_W(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x1;
        logic [31:0] x2;
        logic [3:0]  tag;
        logic [31:0] y;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h40000000, 32'h40400000, 4'd3,  32'h40C00000}; // 2*3
        vecs[1] = '{32'h3FC00000, 32'h3FC00000, 4'd1,  32'h40100000}; // 1.5*1.5
        vecs[2] = '{32'hBF800000, 32'h40000000, 4'd2,  32'hC0000000}; // -1*2
        vecs[3] = '{32'h00000000, 32'h40000000, 4'd5,  32'h00000000}; // zero exponent flush
        vecs[4] = '{32'h3F800000, 32'h3F800000, 4'd6,  32'h3F800000}; // 1*1
        vecs[5] = '{32'h00800000, 32'h3F000000, 4'd7,  32'h00000000}; // exponent underflow
        vecs[6] = '{32'h3FC00001, 32'h3FC00001, 4'd8,  32'h40100001}; // truncation, not rounding
        vecs[7] = '{32'h7F000000, 32'h40000000, 4'd9,  32'h7F800000}; // no saturation
        vecs[8] = '{32'hC0000000, 32'hC0400000, 4'd10, 32'h40C00000}; // neg*neg

        rstn = 1'b0; in_valid = 1'b0; in_x1 = '0; in_x2 = '0; in_tag = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_y",     out_y,          32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        rstn = 1'b1;
        out_ready = 1'b1;
        tick();

        // Table: one request at a time into an empty block
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_x1 = vecs[i].x1; in_x2 = vecs[i].x2; in_tag = vecs[i].tag;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d_lat_valid0", i), 32'(out_valid), 32'd0);
            check($sformatf("v%0d_lat_count1", i), 32'(count),     32'd1);
            tick();
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_y", i),     out_y,          vecs[i].y);
            check($sformatf("v%0d_tag", i),   32'(out_tag),   32'(vecs[i].tag));
            check($sformatf("v%0d_count0", i), 32'(count),    32'd0);
            tick();
            check($sformatf("v%0d_drain", i), 32'(out_valid), 32'd0);
        end

        // Back-to-back: results on consecutive cycles
        in_valid = 1'b1; in_x1 = 32'h3FC00000; in_x2 = 32'h3FC00000; in_tag = 4'd1;
        tick();
        in_x1 = 32'hBF800000; in_x2 = 32'h40000000; in_tag = 4'd2;
        tick();
        in_valid = 1'b0;
        check("b2b_valid1", 32'(out_valid), 32'd1);
        check("b2b_y1",     out_y,          32'h40100000);
        check("b2b_tag1",   32'(out_tag),   32'd1);
        tick();
        check("b2b_valid2", 32'(out_valid), 32'd1);
        check("b2b_y2",     out_y,          32'hC0000000);
        check("b2b_tag2",   32'(out_tag),   32'd2);
        tick();
        check("b2b_drain",  32'(out_valid), 32'd0);

        // Backpressure: capacity DEPTH+1, held output, in-order drain
        out_ready = 1'b0;
        in_x1 = 32'h40000000; in_x2 = 32'h3F800000;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_tag = 4'(i);
            check($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd1);
            tick();
        end
        check("bp_full_ready", 32'(in_ready),  32'd0);
        check("bp_full_count", 32'(count),     32'd4);
        check("bp_full_valid", 32'(out_valid), 32'd1);
        check("bp_full_tag",   32'(out_tag),   32'd0);
        in_tag = 4'd5; in_x1 = 32'h40400000;
        tick();
        tick();
        check("bp_hold_tag",   32'(out_tag),   32'd0);
        check("bp_hold_y",     out_y,          32'h40000000);
        check("bp_hold_count", 32'(count),     32'd4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_out_tag_%0d", i),   32'(out_tag),   32'(i));
            tick();
        end
        check("bp_drained",       32'(out_valid), 32'd0);
        check("bp_drained_count", 32'(count),     32'd0);

        // Reset mid-operation discards everything
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_tag = 4'(12 + i);
            tick();
        end
        in_valid = 1'b0;
        check("mr_pre_count", 32'(count),     32'd3);
        check("mr_pre_valid", 32'(out_valid), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mr_count",    32'(count),     32'd0);
        check("mr_valid",    32'(out_valid), 32'd0);
        check("mr_in_ready", 32'(in_ready),  32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("mr_no_stale_%0d", i), 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
